// File: rtl/sig_checker.sv
// sig_checker: accepts expected values over a valid/ready handshake, waits
// SETTLE cycles, then compares sig_in against the captured value. Counts
// samples and mismatches (saturating), records the first bad value and ends
// the run on stop or after TIMEOUT idle cycles in ARMED.
// Optional build macro: SIG_CHECKER_XCHK_EN. When defined, any X/Z bit on
// sig_in counts as a mismatch. By default an unknown compare counts as a match.
module sig_checker #(
   parameter int WIDTH   = 1,
   parameter int SETTLE  = 1,
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic [WIDTH-1:0] exp_in,
   input  logic             exp_valid,
   output logic             exp_ready,
   input  logic [WIDTH-1:0] sig_in,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             fail,
   output logic             timeout,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] sample_count,
   output logic [WIDTH-1:0] first_bad
);

   localparam int SET_W  = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
   localparam int IDLE_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ARMED, S_SETTLE, S_COMPARE, S_DONE
   } state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   exp_q, exp_d;
   logic [SET_W-1:0]   settle_q, settle_d;
   logic [IDLE_W-1:0]  idle_q, idle_d;
   logic               stop_pend_q, stop_pend_d;
   logic [CNT_W-1:0]   err_q, err_d;
   logic [CNT_W-1:0]   sample_q, sample_d;
   logic [WIDTH-1:0]   first_bad_q, first_bad_d;
   logic               timeout_q, timeout_d;
   logic               pass_d;
   logic               exp_ready_q, busy_q, done_q, pass_q, fail_q;
   logic               xfer;
   logic               mismatch;

   assign xfer = (state_q == S_ARMED) && exp_valid;

   // Mismatch definition: strict 4-state compare or "known-different only".
`ifdef SIG_CHECKER_XCHK_EN
   assign mismatch = (sig_in !== exp_q);
`else
   assign mismatch = ((sig_in != exp_q) === 1'b1);
`endif

   // Next-state and datapath updates for the run-control FSM.
   // NOTE: every variable gets a default first so this block never infers a latch.
   always_comb begin
      state_d     = state_q;
      exp_d       = exp_q;
      settle_d    = settle_q;
      idle_d      = idle_q;
      stop_pend_d = stop_pend_q;
      err_d       = err_q;
      sample_d    = sample_q;
      first_bad_d = first_bad_q;
      timeout_d   = timeout_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d     = S_ARMED;
               idle_d      = '0;
               err_d       = '0;
               sample_d    = '0;
               first_bad_d = '0;
               timeout_d   = 1'b0;
               stop_pend_d = 1'b0;
            end
         end
         S_ARMED: begin
            if (xfer) begin
               exp_d    = exp_in;
               settle_d = SET_W'(SETTLE);
               idle_d   = '0;
               if (stop) stop_pend_d = 1'b1;
               state_d  = (SETTLE == 0) ? S_COMPARE : S_SETTLE;
            end else if (stop) begin
               state_d = S_DONE;
            end else if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
               state_d   = S_DONE;
               timeout_d = 1'b1;
            end else begin
               idle_d = idle_q + 1'b1;
            end
         end
         S_SETTLE: begin
            if (stop) stop_pend_d = 1'b1;
            if (settle_q == SET_W'(1)) state_d = S_COMPARE;
            else                       settle_d = settle_q - 1'b1;
         end
         S_COMPARE: begin
            if (sample_q != '1) sample_d = sample_q + 1'b1;
            if (mismatch) begin
               if (err_q != '1) err_d = err_q + 1'b1;
               if (err_q == '0) first_bad_d = sig_in;
            end
            if (stop_pend_q || stop) begin
               stop_pend_d = 1'b1;
               state_d     = S_DONE;
            end else begin
               state_d = S_ARMED;
               idle_d  = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      pass_d = (state_d == S_DONE) && (err_d == '0) && (sample_d != '0) && !timeout_d;
   end

   // State, datapath and registered status outputs; reset wins over everything.
   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         exp_q       <= '0;
         settle_q    <= '0;
         idle_q      <= '0;
         stop_pend_q <= 1'b0;
         err_q       <= '0;
         sample_q    <= '0;
         first_bad_q <= '0;
         timeout_q   <= 1'b0;
         exp_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         exp_q       <= exp_d;
         settle_q    <= settle_d;
         idle_q      <= idle_d;
         stop_pend_q <= stop_pend_d;
         err_q       <= err_d;
         sample_q    <= sample_d;
         first_bad_q <= first_bad_d;
         timeout_q   <= timeout_d;
         exp_ready_q <= (state_d == S_ARMED);
         busy_q      <= (state_d == S_ARMED) || (state_d == S_SETTLE) || (state_d == S_COMPARE);
         done_q      <= (state_d == S_DONE);
         pass_q      <= pass_d;
         fail_q      <= (state_d == S_DONE) && !pass_d;
      end
   end

   assign exp_ready    = exp_ready_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign pass         = pass_q;
   assign fail         = fail_q;
   assign timeout      = timeout_q;
   assign err_count    = err_q;
   assign sample_count = sample_q;
   assign first_bad    = first_bad_q;

endmodule

// File: tb/tb_sig_checker.sv
// Directed bench for sig_checker: four instances (SETTLE=1, SETTLE=0,
// SETTLE=3, and a 2-bit-counter instance) share one stimulus stream; each
// step checks only the instance it targets.
module tb_sig_checker;

   typedef struct packed {
      logic       exp_ready;
      logic       busy;
      logic       done;
      logic       pass;
      logic       fail;
      logic       timeout;
      logic [7:0] err;
      logic [7:0] sample;
      logic       first_bad;
   } mon_t;

   logic clk = 1'b0;
   logic reset, start, stop, exp_valid;
   logic [0:0] exp_in, sig_in;
   mon_t m1, m0, m3;
   logic       s_ready, s_busy, s_done, s_pass, s_fail, s_timeout;
   logic [1:0] s_err, s_sample;
   logic       s_first_bad;
   logic [0:0] x_val;
   logic       x_exp_err;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   sig_checker #(.WIDTH(1), .SETTLE(1), .CNT_W(8), .TIMEOUT(16)) u_s1 (
      .clk(clk), .reset(reset), .start(start), .stop(stop),
      .exp_in(exp_in), .exp_valid(exp_valid), .exp_ready(m1.exp_ready),
      .sig_in(sig_in), .busy(m1.busy), .done(m1.done), .pass(m1.pass),
      .fail(m1.fail), .timeout(m1.timeout), .err_count(m1.err),
      .sample_count(m1.sample), .first_bad(m1.first_bad));

   sig_checker #(.WIDTH(1), .SETTLE(0), .CNT_W(8), .TIMEOUT(16)) u_s0 (
      .clk(clk), .reset(reset), .start(start), .stop(stop),
      .exp_in(exp_in), .exp_valid(exp_valid), .exp_ready(m0.exp_ready),
      .sig_in(sig_in), .busy(m0.busy), .done(m0.done), .pass(m0.pass),
      .fail(m0.fail), .timeout(m0.timeout), .err_count(m0.err),
      .sample_count(m0.sample), .first_bad(m0.first_bad));

   sig_checker #(.WIDTH(1), .SETTLE(3), .CNT_W(8), .TIMEOUT(16)) u_s3 (
      .clk(clk), .reset(reset), .start(start), .stop(stop),
      .exp_in(exp_in), .exp_valid(exp_valid), .exp_ready(m3.exp_ready),
      .sig_in(sig_in), .busy(m3.busy), .done(m3.done), .pass(m3.pass),
      .fail(m3.fail), .timeout(m3.timeout), .err_count(m3.err),
      .sample_count(m3.sample), .first_bad(m3.first_bad));

   sig_checker #(.WIDTH(1), .SETTLE(0), .CNT_W(2), .TIMEOUT(16)) u_sat (
      .clk(clk), .reset(reset), .start(start), .stop(stop),
      .exp_in(exp_in), .exp_valid(exp_valid), .exp_ready(s_ready),
      .sig_in(sig_in), .busy(s_busy), .done(s_done), .pass(s_pass),
      .fail(s_fail), .timeout(s_timeout), .err_count(s_err),
      .sample_count(s_sample), .first_bad(s_first_bad));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One handshake followed by enough cycles for the SETTLE=1 instance to compare.
   task automatic xfer1(input logic e, input logic s);
      exp_in = e; sig_in = s; exp_valid = 1'b1;
      tick();
      exp_valid = 1'b0;
      tick();
      tick();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; stop = 1'b0; exp_valid = 1'b0;
      exp_in = 1'b0; sig_in = 1'b0;
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      check("rst_busy",   m1.busy, 0);
      check("rst_ready",  m1.exp_ready, 0);
      check("rst_done",   m1.done, 0);
      check("rst_passfail", {m1.pass, m1.fail, m1.timeout}, 0);
      check("rst_counts", {m1.err, m1.sample, m1.first_bad}, 0);

      // stop and exp_valid in IDLE are ignored
      stop = 1'b1; exp_valid = 1'b1;
      tick();
      stop = 1'b0; exp_valid = 1'b0;
      check("idle_ignore", {m1.busy, m1.done, m1.sample}, 0);

      // Basic pass, SETTLE=1
      start = 1'b1;
      tick();
      start = 1'b0;
      check("armed_ready", {m1.exp_ready, m1.busy}, 2'b11);
      xfer1(1'b1, 1'b1);
      check("basic_sample", m1.sample, 1);
      check("basic_busy", m1.busy, 1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("basic_done", {m1.done, m1.pass, m1.fail, m1.timeout}, 4'b1100);
      check("basic_counts", {m1.err, m1.sample}, {8'd0, 8'd1});

      // Mismatches: start in DONE clears counters
      start = 1'b1;
      tick();
      start = 1'b0;
      check("restart_clear", {m1.sample, m1.done}, 0);
      xfer1(1'b0, 1'b0);
      xfer1(1'b0, 1'b1);
      xfer1(1'b0, 1'b1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("mm_err", m1.err, 2);
      check("mm_sample", m1.sample, 3);
      check("mm_first_bad", m1.first_bad, 1);
      check("mm_fail", {m1.done, m1.pass, m1.fail}, 3'b101);

      // X handling: expected result derived from the value actually driven
      start = 1'b1;
      tick();
      start = 1'b0;
      x_val = 1'bx;
`ifdef SIG_CHECKER_XCHK_EN
      x_exp_err = (x_val !== 1'b0);
`else
      x_exp_err = ((x_val != 1'b0) === 1'b1);
`endif
      xfer1(1'b0, x_val);
      check("x_err", m1.err, {31'd0, x_exp_err});
      check("x_sample", m1.sample, 1);
      sig_in = 1'b0;
      stop = 1'b1;
      tick();
      stop = 1'b0;

      // Timeout: 16 idle cycles in ARMED
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 15; i++) tick();
      check("to_not_yet", {m1.busy, m1.done, m1.timeout}, 3'b100);
      tick();
      check("to_flags", {m1.done, m1.timeout, m1.fail, m1.pass}, 4'b1110);
      check("to_counts", {m1.err, m1.sample}, 0);

      // SETTLE=0: transfer and stop together
      do_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      exp_in = 1'b1; sig_in = 1'b1; exp_valid = 1'b1; stop = 1'b1;
      tick();
      exp_valid = 1'b0; stop = 1'b0;
      check("z_inflight", {m0.busy, m0.done, m0.sample}, {1'b1, 1'b0, 8'd0});
      tick();
      check("z_done", {m0.done, m0.pass, m0.busy}, 3'b110);
      check("z_sample", m0.sample, 1);

      // SETTLE=3: exact sampling edge N+4
      do_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      exp_in = 1'b0; sig_in = 1'b0; exp_valid = 1'b1;
      tick();
      exp_valid = 1'b0;
      tick();
      tick();
      tick();
      check("s3_not_yet", m3.sample, 0);
      tick();
      check("s3_sampled", {m3.sample, m3.err}, {8'd1, 8'd0});

      // SETTLE=3: reset one cycle after the transfer discards the compare
      exp_in = 1'b0; sig_in = 1'b1; exp_valid = 1'b1;
      tick();
      exp_valid = 1'b0;
      tick();
      do_reset();
      check("s3_rst_flags", {m3.busy, m3.done, m3.exp_ready, m3.pass, m3.fail, m3.timeout}, 0);
      check("s3_rst_counts", {m3.err, m3.sample, m3.first_bad}, 0);
      for (int i = 0; i < 4; i++) tick();
      check("s3_rst_stays", {m3.busy, m3.sample, m3.err}, 0);

      // Counter saturation on the 2-bit instance (SETTLE=0)
      do_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         exp_in = 1'b0; sig_in = 1'b1; exp_valid = 1'b1;
         tick();
         exp_valid = 1'b0;
         tick();
      end
      check("sat_err", s_err, 3);
      check("sat_sample", s_sample, 3);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("sat_done", {s_done, s_fail, s_first_bad}, 3'b111);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
